toggle_stream_checker: RTL and testbench
========================================

Name: toggle_stream_checker

Overview:
- Receiver-side checker for a toggle-per-tick signal (a flop that inverts every enabled cycle).
- Samples a 1-bit stream and acquires lock once the stream alternates cleanly for LOCK_N consecutive samples.
- Once locked, flags every missed toggle and drops lock after LOSS_N consecutive misses.
- Sits in front of any consumer of an odd/even tick source to qualify it and report errors.

Parameters:
- LOCK_N, 4, consecutive good toggles required to declare lock (1..255).
- LOSS_N, 3, consecutive missed toggles that drop lock (1..255).
- CNT_W, 8, width of error and tick counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_data  input  1  monitored toggle stream
- i_en  input  1  sample qualifier; i_data is sampled only when high
- o_locked  output  1  high while state is LOCKED or SLIP
- o_state  output  2  FSM state: HUNT=0, ACQUIRE=1, LOCKED=2, SLIP=3
- o_expect  output  1  predicted next sample value, ~last sample
- o_err  output  1  one-cycle pulse per missed toggle while locked
- o_err_count  output  CNT_W  saturating count of missed toggles
- o_tick_count  output  CNT_W  wrapping count of good toggles while in LOCKED/SLIP

Behaviour:
- Reset (rst=1 at posedge):
  - State=HUNT; primed, last sample, good_run, bad_run, o_err, o_err_count, o_tick_count all 0.
  - o_expect=1 and o_locked=0.
  - Reset mid-operation discards all history, including lock.
- Sample cycle: a posedge with i_en=1 and rst=0. All outputs are registered and reflect that sample on the next cycle (latency 1).
- i_en=0: all state and counters hold; o_err forced 0.
- First sample after reset only loads the last-sample register and sets primed. No classification, no state change.
- Classification on later samples:
  - good = (i_data != last sample).
  - bad = (i_data == last sample).
  - The last-sample register always updates to i_data.
- FSM transitions, evaluated on sample cycles only:
  - HUNT, good: go to ACQUIRE, good_run=1 (LOCK_N=1: go straight to LOCKED).
  - HUNT, bad: stay in HUNT.
  - ACQUIRE, good: good_run+1; when good_run+1 == LOCK_N go to LOCKED and clear good_run.
  - ACQUIRE, bad: go to HUNT, good_run=0.
  - LOCKED, good: o_tick_count+1.
  - LOCKED, bad: o_err=1, o_err_count+1, bad_run=1, go to SLIP (LOSS_N=1: go straight to HUNT).
  - SLIP, good: go to LOCKED, bad_run=0, o_tick_count+1.
  - SLIP, bad: o_err=1, o_err_count+1, bad_run+1; when bad_run+1 == LOSS_N go to HUNT and clear bad_run.
- Counters:
  - o_err_count saturates at 2^CNT_W-1 and is not cleared on loss of lock; only rst clears it.
  - o_tick_count wraps modulo 2^CNT_W.
  - good_run and bad_run are 8 bits.
- o_err is high for exactly one cycle per bad sample in LOCKED/SLIP. It is never asserted in HUNT or ACQUIRE.
- o_expect = ~last sample, updated with each sample.

Decomposition:
- Shared package holds:
  - 2-bit state type and the four state constants.
  - Default LOCK_N and LOSS_N constants.
- One natural sub-module: sat_counter (parameter W; inc, clr inputs; saturating value out), used for o_err_count.
- FSM, run counters and tick counter stay in the top module.

Test Plan (LOCK_N=4, LOSS_N=3, CNT_W=8):
- Reset, i_en=1, i_data = 0,1,0,1,0 → HUNT after first sample; ACQUIRE, good_run 1..3; o_state=2 and o_locked=1 one cycle after the 5th sample; o_err never high.
- Locked, feed 1,0,1 then 1 (repeat) → o_err single pulse, o_err_count=1, o_state=3; next sample 0 returns o_state=2, o_tick_count keeps incrementing.
- Locked, hold i_data=1 for 3 samples → three o_err pulses, o_err_count=3, o_state=0 and o_locked=0 after the 3rd.
- Toggle stream with i_en low on alternate cycles (i_data constant during gaps) → state and counters frozen during gaps, lock still achieved after 4 good samples, no errors.
- Locked, hold constant input for 300 samples (re-locking in between) → o_err_count stops at 255, no wrap; o_tick_count after 256 good locked samples returns to 0.
- Assert rst for one cycle while in SLIP with o_err_count=5 → next cycle o_state=0, o_err_count=0, o_tick_count=0, o_expect=1; next sample only primes.

Source files
------------

// File: rtl/toggle_stream_checker_pkg.sv
// Shared types and defaults for the toggle stream checker.
// Holds the lock FSM state encoding and the default lock/loss thresholds.
package toggle_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_SLIP    = 2'd3
  } state_t;

  localparam int DEFAULT_LOCK_N = 4;
  localparam int DEFAULT_LOSS_N = 3;
  localparam int RUN_W          = 8;

endpackage

// File: rtl/toggle_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= sat_inc(value);
    end
  end

endmodule

// File: rtl/toggle_stream_checker.sv
// Receiver-side checker for a toggle-per-tick stream: acquires lock after
// LOCK_N clean toggles, flags missed toggles and drops lock after LOSS_N misses.
module toggle_stream_checker
  import toggle_stream_checker_pkg::*;
#(
  parameter int LOCK_N = DEFAULT_LOCK_N,
  parameter int LOSS_N = DEFAULT_LOSS_N,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data,
  input  logic             i_en,
  output logic             o_locked,
  output logic [1:0]       o_state,
  output logic             o_expect,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_tick_count
);

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] LOSS_RUN = RUN_W'(LOSS_N);

  state_t             state_p0, state_nxt;
  logic               primed_p0, primed_nxt;
  logic               last_p0, last_nxt;
  logic [RUN_W-1:0]   good_run_p0, good_run_nxt;
  logic [RUN_W-1:0]   bad_run_p0, bad_run_nxt;
  logic [CNT_W-1:0]   tick_p0, tick_nxt;
  logic               err_p0, err_nxt;
  logic               err_inc;
  logic               good;

  assign good = (i_data != last_p0);

  always_comb begin
    state_nxt    = state_p0;
    primed_nxt   = primed_p0;
    last_nxt     = last_p0;
    good_run_nxt = good_run_p0;
    bad_run_nxt  = bad_run_p0;
    tick_nxt     = tick_p0;
    err_nxt      = 1'b0;
    err_inc      = 1'b0;

    if (i_en) begin
      last_nxt   = i_data;
      primed_nxt = 1'b1;
      // The very first sample only establishes a reference; nothing to classify yet.
      if (primed_p0) begin
        unique case (state_p0)
          ST_HUNT: begin
            if (good) begin
              if (LOCK_RUN == RUN_W'(1)) begin
                state_nxt    = ST_LOCKED;
                good_run_nxt = '0;
              end else begin
                state_nxt    = ST_ACQUIRE;
                good_run_nxt = RUN_W'(1);
              end
            end
          end
          ST_ACQUIRE: begin
            if (good) begin
              if (good_run_p0 + RUN_W'(1) == LOCK_RUN) begin
                state_nxt    = ST_LOCKED;
                good_run_nxt = '0;
              end else begin
                good_run_nxt = good_run_p0 + RUN_W'(1);
              end
            end else begin
              state_nxt    = ST_HUNT;
              good_run_nxt = '0;
            end
          end
          ST_LOCKED: begin
            if (good) begin
              tick_nxt = tick_p0 + CNT_W'(1);
            end else begin
              err_nxt = 1'b1;
              err_inc = 1'b1;
              if (LOSS_RUN == RUN_W'(1)) begin
                state_nxt   = ST_HUNT;
                bad_run_nxt = '0;
              end else begin
                state_nxt   = ST_SLIP;
                bad_run_nxt = RUN_W'(1);
              end
            end
          end
          ST_SLIP: begin
            if (good) begin
              state_nxt   = ST_LOCKED;
              bad_run_nxt = '0;
              tick_nxt    = tick_p0 + CNT_W'(1);
            end else begin
              err_nxt = 1'b1;
              err_inc = 1'b1;
              if (bad_run_p0 + RUN_W'(1) == LOSS_RUN) begin
                state_nxt   = ST_HUNT;
                bad_run_nxt = '0;
              end else begin
                bad_run_nxt = bad_run_p0 + RUN_W'(1);
              end
            end
          end
          default: begin
            state_nxt = ST_HUNT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_HUNT;
      primed_p0   <= 1'b0;
      last_p0     <= 1'b0;
      good_run_p0 <= '0;
      bad_run_p0  <= '0;
      tick_p0     <= '0;
      err_p0      <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      primed_p0   <= primed_nxt;
      last_p0     <= last_nxt;
      good_run_p0 <= good_run_nxt;
      bad_run_p0  <= bad_run_nxt;
      tick_p0     <= tick_nxt;
      err_p0      <= err_nxt;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (err_inc),
    .value(o_err_count)
  );

  assign o_state      = state_p0;
  assign o_locked     = (state_p0 == ST_LOCKED) || (state_p0 == ST_SLIP);
  assign o_expect     = ~last_p0;
  assign o_err        = err_p0;
  assign o_tick_count = tick_p0;

endmodule

// File: tb/tb_toggle_stream_checker.sv
// Bench for toggle_stream_checker: hand-computed vector table, then long
// lock/slip sequences whose expectations come from a small behavioural model.
module tb_toggle_stream_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_data;
  logic             i_en;
  logic             o_locked;
  logic [1:0]       o_state;
  logic             o_expect;
  logic             o_err;
  logic [CNT_W-1:0] o_err_count;
  logic [CNT_W-1:0] o_tick_count;

  always #5 clk = ~clk;

  toggle_stream_checker #(
    .LOCK_N(LOCK_N),
    .LOSS_N(LOSS_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_en        (i_en),
    .o_locked    (o_locked),
    .o_state     (o_state),
    .o_expect    (o_expect),
    .o_err       (o_err),
    .o_err_count (o_err_count),
    .o_tick_count(o_tick_count)
  );

  typedef struct packed {
    logic [1:0]       st;
    logic             lck;
    logic             expv;
    logic             err;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] tk;
  } out_t;

  typedef struct {
    logic r;
    logic en;
    logic d;
    out_t exp;
  } vec_t;

  out_t sbq[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural reference state
  int   m_st, m_gr, m_br, m_ec, m_tk;
  logic m_pr, m_last, m_err;

  function automatic vec_t mk(input logic r, en, d, input int st, lck, ex, err, ec, tk);
    vec_t v;
    v.r = r; v.en = en; v.d = d;
    v.exp.st = 2'(st); v.exp.lck = lck[0]; v.exp.expv = ex[0]; v.exp.err = err[0];
    v.exp.ec = CNT_W'(ec); v.exp.tk = CNT_W'(tk);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, en, d, input out_t e);
    out_t want;
    @(negedge clk);
    rst = r; i_en = en; i_data = d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      want = sbq.pop_front();
      chk("state",    32'(o_state),      32'(want.st));
      chk("locked",   32'(o_locked),     32'(want.lck));
      chk("expect",   32'(o_expect),     32'(want.expv));
      chk("err",      32'(o_err),        32'(want.err));
      chk("err_count",32'(o_err_count),  32'(want.ec));
      chk("tick",     32'(o_tick_count), 32'(want.tk));
    end
  endtask

  task automatic model(input logic r, en, d, output out_t e);
    if (r) begin
      m_st = 0; m_gr = 0; m_br = 0; m_ec = 0; m_tk = 0;
      m_pr = 1'b0; m_last = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (en) begin
        if (m_pr) begin
          if (d != m_last) begin
            if (m_st == 0) begin m_st = 1; m_gr = 1; end
            else if (m_st == 1) begin
              m_gr++;
              if (m_gr == LOCK_N) begin m_st = 2; m_gr = 0; end
            end
            else begin m_st = 2; m_br = 0; m_tk = (m_tk + 1) % 256; end
          end else begin
            if (m_st == 1) begin m_st = 0; m_gr = 0; end
            else if (m_st >= 2) begin
              m_err = 1'b1;
              if (m_ec < 255) m_ec++;
              m_br++;
              m_st = 3;
              if (m_br == LOSS_N) begin m_st = 0; m_br = 0; end
            end
          end
        end
        m_pr = 1'b1;
        m_last = d;
      end
    end
    e.st = 2'(m_st); e.lck = (m_st >= 2); e.expv = ~m_last; e.err = m_err;
    e.ec = CNT_W'(m_ec); e.tk = CNT_W'(m_tk);
  endtask

  task automatic run(input logic r, en, d);
    out_t e;
    model(r, en, d, e);
    apply(r, en, d, e);
  endtask

  initial begin
    logic d;
    rst = 1'b1; i_en = 1'b0; i_data = 1'b0;

    //          r  en d   st lck ex err ec tk
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 0, 2, 1, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 1, 2, 1, 1, 0, 1, 4));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 5));
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 2, 5));
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 3, 5));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 4, 5));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4, 5));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 4, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 4, 5));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4, 5));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4, 5));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 4, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4, 5));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4, 5));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4, 5));
    tbl.push_back(mk(0, 1, 0, 2, 1, 1, 0, 4, 5));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 4, 6));
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 5, 6));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i].r, tbl[i].en, tbl[i].d, tbl[i].exp);

    // Tick counter wrap: lock, then 256 good locked samples.
    run(1'b1, 1'b0, 1'b0);
    d = 1'b0;
    run(1'b0, 1'b1, d);
    for (int i = 0; i < LOCK_N; i++) begin d = ~d; run(1'b0, 1'b1, d); end
    for (int i = 0; i < 256; i++) begin d = ~d; run(1'b0, 1'b1, d); end
    chk("tick_wrap", 32'(o_tick_count), 32'd0);
    chk("tick_wrap_state", 32'(o_state), 32'd2);

    // Error saturation: repeated loss of lock and re-acquisition, 300 misses total.
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < LOSS_N; i++) run(1'b0, 1'b1, d);
      for (int i = 0; i < LOCK_N; i++) begin d = ~d; run(1'b0, 1'b1, d); end
    end
    chk("err_sat", 32'(o_err_count), 32'd255);
    chk("err_sat_locked", 32'(o_locked), 32'd1);

    // A little random traffic with sparse enables, then a reset.
    for (int i = 0; i < 200; i++) begin
      d = ($urandom_range(0, 3) == 0) ? d : ~d;
      run(1'b0, 1'($urandom_range(0, 1)), d);
    end
    run(1'b1, 1'b1, d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
